// File: rtl/dds_sweep_ctrl.sv
// Timed linear frequency sweep sequencer feeding the DDS core step port (one-shot/repeat/triangle).
// Optional crossing marker output is enabled with `define DDS_SWEEP_MARKER_EN.
module dds_sweep_ctrl #(
    parameter int unsigned STEP_W  = 32,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [STEP_W-1:0]  idle_step,
    input  logic [STEP_W-1:0]  start_step,
    input  logic [STEP_W-1:0]  stop_step,
    input  logic [STEP_W-1:0]  delta,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DDS_SWEEP_MARKER_EN
    input  logic [STEP_W-1:0]  marker_step,
    output logic               marker,
`endif
    output logic [STEP_W-1:0]  step_out,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [STEP_W-1:0]  start_q, start_d, stop_q, stop_d, delta_q, delta_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d, rev_q, rev_d, last_q, last_d;
    logic               done_q, done_d, wrap_q, wrap_d;
    logic               accept;
    logic [STEP_W-1:0]  target, back_target;

    // Returns {hit_endpoint, next_point}; clamps on overshoot or wraparound of the STEP_W range.
    function automatic logic [STEP_W:0] advance(input logic [STEP_W-1:0] cur,
                                                input logic              up,
                                                input logic [STEP_W-1:0] tgt,
                                                input logic [STEP_W-1:0] dlt);
        logic [STEP_W:0] nxt;
        logic            clamp;
        if (up) begin
            nxt   = {1'b0, cur} + {1'b0, dlt};
            clamp = nxt[STEP_W] || (nxt[STEP_W-1:0] >= tgt);
        end else begin
            nxt   = {1'b0, cur} - {1'b0, dlt};
            clamp = nxt[STEP_W] || (nxt[STEP_W-1:0] <= tgt);
        end
        return clamp ? {1'b1, tgt} : {1'b0, nxt[STEP_W-1:0]};
    endfunction

    assign accept      = (state_q == StIdle) && start && !abort && (delta != '0);
    assign target      = rev_q ? start_q : stop_q;
    assign back_target = rev_q ? stop_q : start_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        start_d = start_q;
        stop_d  = stop_q;
        delta_d = delta_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rev_d   = rev_q;
        last_d  = last_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                step_d = idle_step;
                if (accept) begin
                    state_d = StRun;
                    start_d = start_step;
                    stop_d  = stop_step;
                    delta_d = delta;
                    dwell_d = dwell;
                    mode_d  = mode;
                    step_d  = start_step;
                    cnt_d   = dwell;
                    dir_d   = (start_step <= stop_step);
                    rev_d   = 1'b0;
                    last_d  = (start_step == stop_step);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    step_d  = idle_step;
                    last_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = dwell_q;
                    if (!last_q) begin
                        {last_d, step_d} = advance(step_q, dir_q, target, delta_q);
                    end else begin
                        case (mode_q)
                            2'd1: begin
                                step_d = start_q;
                                wrap_d = 1'b1;
                                last_d = (start_q == stop_q);
                            end
                            2'd2: begin
                                // Turn around and step one delta back toward the opposite end.
                                dir_d  = !dir_q;
                                rev_d  = !rev_q;
                                wrap_d = 1'b1;
                                {last_d, step_d} = advance(step_q, !dir_q, back_target, delta_q);
                            end
                            default: begin
                                state_d = StIdle;
                                step_d  = idle_step;
                                done_d  = 1'b1;
                                last_d  = 1'b0;
                            end
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            delta_q <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            rev_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            delta_q <= delta_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rev_q   <= rev_d;
            last_q  <= last_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign step_out = step_q;
    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign wrap     = wrap_q;

`ifdef DDS_SWEEP_MARKER_EN
    logic [STEP_W-1:0] mk_q, mk_d;
    logic              armed_q, armed_d, marker_q, marker_d;
    logic              arm_eff, hit, run_d;

    // Armed once per pass; fires on the first point at or beyond the marker in the travel direction.
    always_comb begin
        mk_d     = accept ? marker_step : mk_q;
        arm_eff  = armed_q || accept || wrap_d;
        hit      = dir_d ? (step_d >= mk_d) : (step_d <= mk_d);
        run_d    = (state_d == StRun);
        marker_d = run_d && arm_eff && hit;
        armed_d  = run_d && arm_eff && !hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mk_q     <= '0;
            armed_q  <= 1'b0;
            marker_q <= 1'b0;
        end else begin
            mk_q     <= mk_d;
            armed_q  <= armed_d;
            marker_q <= marker_d;
        end
    end

    assign marker = marker_q;
`endif

endmodule
